// File: rtl/hdmi_timing_ctrl.sv
// HDMI raster timing generator with double-buffered timing registers.
// Drives VDE/hsync/vsync and a one-cycle-early pixel fetch request.
module hdmi_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        commit_done,
  output logic        cfg_err,
  output logic [11:0] counter_x,
  output logic [11:0] counter_y,
  output logic        pix_req,
  output logic        draw_area,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        line_start,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0][11:0] DEFAULTS = {
    12'(V_BP), 12'(V_SYNC), 12'(V_FP), 12'(V_ACTIVE),
    12'(H_BP), 12'(H_SYNC), 12'(H_FP), 12'(H_ACTIVE)
  };

  state_t cur, nxt;
  logic [7:0][11:0] pend, act, pend_eff;
  logic        req, req_nxt;
  logic        apply, reject;
  logic [13:0] a_htot, a_vtot, p_htot, p_vtot;
  logic [13:0] cx, cy;
  logic [13:0] hs_lo, hs_hi, vs_lo, vs_hi;
  logic        p_ok, running, line_end, frame_end;
  logic        hs_cond, vs_cond;

  function automatic logic [13:0] tot4(
    input logic [11:0] a,
    input logic [11:0] b,
    input logic [11:0] c,
    input logic [11:0] d
  );
    return 14'(a) + 14'(b) + 14'(c) + 14'(d);
  endfunction

  // Same-cycle write is folded into the set a commit sees
  always_comb begin
    pend_eff = pend;
    if (cfg_wr) pend_eff[cfg_addr] = cfg_wdata;
  end

  assign a_htot = tot4(act[0], act[1], act[2], act[3]);
  assign a_vtot = tot4(act[4], act[5], act[6], act[7]);
  assign p_htot = tot4(pend_eff[0], pend_eff[1],
                       pend_eff[2], pend_eff[3]);
  assign p_vtot = tot4(pend_eff[4], pend_eff[5],
                       pend_eff[6], pend_eff[7]);

  assign p_ok = (pend_eff[0] != 12'd0) &&
                (pend_eff[4] != 12'd0) &&
                (p_htot <= 14'd4096) &&
                (p_vtot <= 14'd4096);

  assign cx        = {2'b00, counter_x};
  assign cy        = {2'b00, counter_y};
  assign running   = (cur != IDLE);
  assign line_end  = (cx == a_htot - 14'd1);
  assign frame_end = line_end && (cy == a_vtot - 14'd1);

  assign hs_lo = 14'(act[0]) + 14'(act[1]);
  assign hs_hi = hs_lo + 14'(act[2]);
  assign vs_lo = 14'(act[4]) + 14'(act[5]);
  assign vs_hi = vs_lo + 14'(act[6]);

  assign hs_cond = (cx >= hs_lo) && (cx < hs_hi);
  assign vs_cond = (cy >= vs_lo) && (cy < vs_hi);

  assign pix_req = running &&
                   (cx < 14'(act[0])) &&
                   (cy < 14'(act[4]));

  assign state = cur;

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:  if (enable) nxt = RUN;
      RUN:   if (!enable) nxt = frame_end ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)         nxt = RUN;
        else if (frame_end) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Commits while the raster runs wait for the frame boundary
  always_comb begin
    apply   = 1'b0;
    reject  = 1'b0;
    req_nxt = req;
    if (cfg_commit) begin
      if (!p_ok) begin
        reject  = 1'b1;
        req_nxt = 1'b0;
      end else if (!running) begin
        apply = 1'b1;
      end else begin
        req_nxt = 1'b1;
      end
    end
    if (running && frame_end && req_nxt) begin
      req_nxt = 1'b0;
      if (p_ok) apply  = 1'b1;
      else      reject = 1'b1;
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      cur         <= IDLE;
      req         <= 1'b0;
      pend        <= DEFAULTS;
      act         <= DEFAULTS;
      counter_x   <= 12'd0;
      counter_y   <= 12'd0;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
      draw_area   <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cur         <= nxt;
      req         <= req_nxt;
      commit_done <= apply;
      cfg_err     <= reject;
      if (cfg_wr) pend[cfg_addr] <= cfg_wdata;
      if (apply)  act <= pend_eff;
      if (!running || frame_end) begin
        counter_x <= 12'd0;
        counter_y <= 12'd0;
      end else if (line_end) begin
        counter_x <= 12'd0;
        counter_y <= counter_y + 12'd1;
      end else begin
        counter_x <= counter_x + 12'd1;
      end
      draw_area   <= pix_req;
      hsync       <= running && hs_cond;
      vsync       <= running && vs_cond;
      line_start  <= running && (cx == 14'd0);
      frame_start <= running && (cx == 14'd0) &&
                     (cy == 14'd0);
    end
  end

endmodule
